arbitro_mux: RTL and testbench

ARBITRO_MUX -- requirements
Module: arbitro_mux

---
 rtl/arbitro_pkg.sv | 18 +
 rtl/Mux_2a1.sv | 13 +
 rtl/arbitro_mux.sv | 101 ++++++++++
 tb/tb_arbitro_mux.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/arbitro_pkg.sv
// Shared definitions for the two-requester arbiter/mux: state encoding and
// default parameter values.
package arbitro_pkg;

  localparam int ANCHO_DEF      = 6;
  localparam int MAX_RAFAGA_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SERV0 = 2'b01,
    SERV1 = 2'b10
  } estado_e;

  function automatic estado_e otro_serv(estado_e s);
    return (s == SERV0) ? SERV1 : SERV0;
  endfunction

endpackage

// File: rtl/Mux_2a1.sv
// Two-to-one data multiplexer, width-parameterised.
module Mux_2a1 #(
  parameter int W = 1
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         sel_i,
  output logic [W-1:0] y_o
);

  assign y_o = sel_i ? b_i : a_i;

endmodule

// File: rtl/arbitro_mux.sv
// Two-requester burst arbiter feeding a single registered output word with
// valid/ready handshake downstream.
module arbitro_mux
  import arbitro_pkg::*;
#(
  parameter int ANCHO      = ANCHO_DEF,
  parameter int MAX_RAFAGA = MAX_RAFAGA_DEF
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic             REQ0,
  input  logic             REQ1,
  input  logic [ANCHO-1:0] DATO0,
  input  logic [ANCHO-1:0] DATO1,
  input  logic             LISTO,
  output logic             GNT0,
  output logic             GNT1,
  output logic             SEL,
  output logic [ANCHO-1:0] Y,
  output logic             VALIDO
);

  localparam logic [3:0] MAX_C = 4'(MAX_RAFAGA);

  estado_e          state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             ultimo_q, ultimo_d;
  logic [ANCHO-1:0] y_q, y_d, mux_y;
  logic             valido_q, valido_d;
  logic             req_own, req_otro, toma, fin_rafaga;

  Mux_2a1 #(.W(ANCHO)) u_mux (
    .a_i  (DATO0),
    .b_i  (DATO1),
    .sel_i(SEL),
    .y_o  (mux_y)
  );

  assign GNT0   = (state_q == SERV0);
  assign GNT1   = (state_q == SERV1);
  assign SEL    = (state_q == SERV1);
  assign Y      = y_q;
  assign VALIDO = valido_q;

  always_comb begin
    req_own    = (state_q == SERV1) ? REQ1 : REQ0;
    req_otro   = (state_q == SERV1) ? REQ0 : REQ1;
    // The output register frees up in the same cycle it is consumed.
    toma       = (state_q != IDLE) && req_own && (!valido_q || LISTO);
    fin_rafaga = toma && ((cnt_q + 4'd1) == MAX_C);

    y_d      = y_q;
    valido_d = valido_q;
    if (toma) begin
      y_d      = mux_y;
      valido_d = 1'b1;
    end else if (valido_q && LISTO) begin
      valido_d = 1'b0;
    end

    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (REQ0 && REQ1) state_d = ultimo_q ? SERV0 : SERV1;
        else if (REQ0)    state_d = SERV0;
        else if (REQ1)    state_d = SERV1;
      end
      SERV0, SERV1: begin
        if (!req_own)                    state_d = req_otro ? otro_serv(state_q) : IDLE;
        else if (fin_rafaga && req_otro) state_d = otro_serv(state_q);
      end
      default: state_d = IDLE;
    endcase

    // A full burst with nobody waiting just restarts the count.
    cnt_d = cnt_q;
    if (state_d != state_q) cnt_d = 4'd0;
    else if (fin_rafaga)    cnt_d = 4'd0;
    else if (toma)          cnt_d = cnt_q + 4'd1;

    ultimo_d = ultimo_q;
    if (state_q != IDLE && state_d != state_q) ultimo_d = (state_q == SERV1);
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      ultimo_q <= 1'b1;
      y_q      <= '0;
      valido_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ultimo_q <= ultimo_d;
      y_q      <= y_d;
      valido_q <= valido_d;
    end
  end

endmodule

// File: tb/tb_arbitro_mux.sv
// Bench for arbitro_mux: directed vector table, corner sequences, and a
// random run against an owner/burst reference model.
module tb_arbitro_mux;

  logic       CLK, RST_n, REQ0, REQ1, LISTO;
  logic [5:0] DATO0, DATO1, Y;
  logic       GNT0, GNT1, SEL, VALIDO;

  int total = 0;
  int bad   = 0;

  arbitro_mux #(.ANCHO(6), .MAX_RAFAGA(4)) dut (
    .CLK(CLK), .RST_n(RST_n), .REQ0(REQ0), .REQ1(REQ1),
    .DATO0(DATO0), .DATO1(DATO1), .LISTO(LISTO),
    .GNT0(GNT0), .GNT1(GNT1), .SEL(SEL), .Y(Y), .VALIDO(VALIDO)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  typedef struct {
    logic       rst_n, r0, r1;
    logic [5:0] d0, d1;
    logic       listo;
    logic       g0, g1, v;
    logic [5:0] y;
  } vec_t;

  vec_t tv[17];

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  // Packed view: {GNT0, GNT1, SEL, VALIDO, Y}
  task automatic chk(input string nm, input logic g0, input logic g1, input logic v, input logic [5:0] y);
    logic [9:0] act, exp;
    act = {GNT0, GNT1, SEL, VALIDO, Y};
    exp = {g0, g1, g1, v, y};
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got g0=%b g1=%b sel=%b v=%b y=%0d, want g0=%b g1=%b sel=%b v=%b y=%0d",
               nm, GNT0, GNT1, SEL, VALIDO, Y, g0, g1, g1, v, y);
    end
  endtask

  task automatic pulse_reset();
    RST_n = 1'b0;
    cyc();
    RST_n = 1'b1;
  endtask

  // Reference model: who owns the output, how many words taken this grant,
  // who was served last, and the output word.
  int         m_own, m_cnt, m_last;
  logic [5:0] m_y;
  logic       m_v;
  logic       rq[2];
  logic [5:0] dt[2];

  task automatic model_reset();
    m_own = -1; m_cnt = 0; m_last = 1; m_y = '0; m_v = 1'b0;
  endtask

  task automatic model_step();
    int  nxt, oth;
    bit  take;
    take = (m_own >= 0) && rq[m_own] && (!m_v || LISTO);
    nxt  = m_own;
    if (m_own < 0) begin
      if (rq[0] && rq[1]) nxt = 1 - m_last;
      else if (rq[0])     nxt = 0;
      else if (rq[1])     nxt = 1;
    end else begin
      oth = 1 - m_own;
      if (!rq[m_own])                         nxt = rq[oth] ? oth : -1;
      else if (take && m_cnt + 1 == 4 && rq[oth]) nxt = oth;
    end
    if (take) begin
      m_y = dt[m_own];
      m_v = 1'b1;
    end else if (m_v && LISTO) begin
      m_v = 1'b0;
    end
    if (nxt != m_own) begin
      if (m_own >= 0) m_last = m_own;
      m_cnt = 0;
    end else if (take) begin
      m_cnt = (m_cnt + 1 == 4) ? 0 : m_cnt + 1;
    end
    m_own = nxt;
  endtask

  initial begin
    RST_n = 1'b0; REQ0 = 1'b0; REQ1 = 1'b0; DATO0 = '0; DATO1 = '0; LISTO = 1'b1;

    //           rst r0 r1  d0  d1 ls  g0 g1 v  y
    tv[0]  = '{1'b0,1,1, 9, 42, 1,  0, 0, 0, 0};
    tv[1]  = '{1'b0,1,1, 9, 42, 1,  0, 0, 0, 0};
    tv[2]  = '{1'b1,1,1, 9, 42, 1,  1, 0, 0, 0};
    tv[3]  = '{1'b1,1,1, 9, 42, 1,  1, 0, 1, 9};
    tv[4]  = '{1'b1,1,1, 9, 42, 1,  1, 0, 1, 9};
    tv[5]  = '{1'b1,1,1, 9, 42, 1,  1, 0, 1, 9};
    tv[6]  = '{1'b1,1,1, 9, 42, 1,  0, 1, 1, 9};
    tv[7]  = '{1'b1,1,1, 9, 42, 1,  0, 1, 1, 42};
    tv[8]  = '{1'b1,1,1, 9, 42, 1,  0, 1, 1, 42};
    tv[9]  = '{1'b1,1,1, 9, 42, 1,  0, 1, 1, 42};
    tv[10] = '{1'b1,1,1, 9, 42, 1,  1, 0, 1, 42};
    tv[11] = '{1'b1,1,1, 9, 42, 1,  1, 0, 1, 9};
    tv[12] = '{1'b0,0,0, 9, 42, 1,  0, 0, 0, 0};
    tv[13] = '{1'b1,1,0, 9, 42, 1,  1, 0, 0, 0};
    tv[14] = '{1'b1,1,0, 9, 42, 1,  1, 0, 1, 9};
    tv[15] = '{1'b1,0,0, 9, 42, 1,  0, 0, 0, 9};
    tv[16] = '{1'b1,0,0, 9, 42, 1,  0, 0, 0, 9};

    for (int i = 0; i < 17; i++) begin
      RST_n = tv[i].rst_n; REQ0 = tv[i].r0; REQ1 = tv[i].r1;
      DATO0 = tv[i].d0; DATO1 = tv[i].d1; LISTO = tv[i].listo;
      cyc();
      chk($sformatf("vec%0d", i), tv[i].g0, tv[i].g1, tv[i].v, tv[i].y);
    end

    // Backpressure mid-burst, then owner drop with the other side waiting.
    REQ0 = 1; REQ1 = 1; DATO0 = 6'd17; DATO1 = 6'd50; LISTO = 1;
    pulse_reset();
    cyc(); chk("bp_grant", 1, 0, 0, 0);
    cyc(); chk("bp_cap1", 1, 0, 1, 17);
    cyc(); chk("bp_cap2", 1, 0, 1, 17);
    LISTO = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(); chk($sformatf("bp_hold%0d", i), 1, 0, 1, 17);
    end
    LISTO = 1;
    cyc(); chk("bp_cap3", 1, 0, 1, 17);
    cyc(); chk("bp_cap4_switch", 0, 1, 1, 17);
    cyc(); chk("bp_other_word", 0, 1, 1, 50);
    REQ1 = 0;
    cyc(); chk("drop_to_g0", 1, 0, 0, 50);
    cyc(); chk("drop_first_word", 1, 0, 1, 17);

    // Reset in the middle of a burst, after requester 1 won a tie.
    REQ0 = 1; REQ1 = 0; DATO0 = 6'd5; DATO1 = 6'd33;
    pulse_reset();
    cyc(); chk("mr_g0", 1, 0, 0, 0);
    cyc(); chk("mr_w0", 1, 0, 1, 5);
    REQ0 = 0;
    cyc(); chk("mr_idle", 0, 0, 0, 5);
    REQ0 = 1; REQ1 = 1;
    cyc(); chk("mr_tie_to_1", 0, 1, 0, 5);
    cyc(); chk("mr_cap1", 0, 1, 1, 33);
    cyc(); chk("mr_cap2", 0, 1, 1, 33);
    #2 RST_n = 0;
    #1 chk("mr_async_clear", 0, 0, 0, 0);
    @(posedge CLK); #1;
    RST_n = 1;
    cyc(); chk("mr_tie_to_0", 1, 0, 0, 0);

    // Random traffic against the model.
    rq[0] = 0; rq[1] = 0; dt[0] = '0; dt[1] = '0;
    REQ0 = 0; REQ1 = 0;
    pulse_reset();
    model_reset();
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (!rq[k]) begin
          if ($urandom_range(0, 9) < 4) begin
            rq[k] = 1'b1;
            dt[k] = 6'($urandom);
          end
        end else if ($urandom_range(0, 9) < 1) begin
          rq[k] = 1'b0;
        end
      end
      REQ0 = rq[0]; REQ1 = rq[1]; DATO0 = dt[0]; DATO1 = dt[1];
      LISTO = ($urandom_range(0, 9) < 7);
      model_step();
      cyc();
      chk($sformatf("rnd%0d", c), m_own == 0, m_own == 1, m_v, m_y);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
